// File: rtl/qpl_pkg.sv
// Shared types and default widths for the QuickPageLite stream ingress slice.
package qpl_pkg;

    localparam int QPL_DATA_W  = 32;
    localparam int QPL_USER_W  = 8;
    localparam int QPL_BLOCK_W = 8;
    localparam int QPL_OFF_W   = 3;
    localparam int QPL_LEN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DESC = 2'd2
    } state_t;

    // Descriptor fields are sized by the package defaults; the ingress top is
    // expected to be instantiated with matching widths.
    typedef struct packed {
        logic [QPL_BLOCK_W-1:0] head;
        logic [QPL_LEN_W-1:0]   len;
        logic [QPL_USER_W-1:0]  user;
        logic                   ovf;
    } desc_t;

endpackage

// File: rtl/qpl_blk_prefetch.sv
// Spare-block register: keeps one allocator block ready so a packet start or a
// block boundary never has to wait for a request round trip when grants are timely.
module qpl_blk_prefetch
    import qpl_pkg::*;
#(
    parameter int BLOCK_W = QPL_BLOCK_W
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_blk_full,
    input  logic               i_alloc_gnt,
    input  logic [BLOCK_W-1:0] i_alloc_idx,
    input  logic               i_consume,
    output logic               o_alloc_req,
    output logic               o_nxt_vld,
    output logic [BLOCK_W-1:0] o_nxt_idx
);

    logic               nxt_vld_reg;
    logic [BLOCK_W-1:0] nxt_idx_reg;
    logic               want_blk;
    logic               load;

    assign want_blk = !nxt_vld_reg && !i_blk_full;

    // A grant only counts when it answers a live request; stray grants are dropped.
    assign load = i_alloc_gnt && want_blk;

    // Request is held low while reset is asserted so every output reads zero.
    assign o_alloc_req = i_rstn && want_blk;
    assign o_nxt_vld   = nxt_vld_reg;
    assign o_nxt_idx   = nxt_idx_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            nxt_vld_reg <= 1'b0;
            nxt_idx_reg <= '0;
        end else if (i_consume) begin
            nxt_vld_reg <= 1'b0;
        end else if (load) begin
            nxt_vld_reg <= 1'b1;
            nxt_idx_reg <= i_alloc_idx;
        end
    end

endmodule

// File: rtl/qpl_strm_ingress.sv
// Stream ingress for one QuickPageLite channel: packs beats into allocator blocks,
// links blocks lazily through the aux port and emits one descriptor per packet.
module qpl_strm_ingress
    import qpl_pkg::*;
#(
    parameter int  DATA_W  = QPL_DATA_W,
    parameter int  USER_W  = QPL_USER_W,
    parameter int  BLOCK_W = QPL_BLOCK_W,
    parameter int  OFF_W   = QPL_OFF_W,
    parameter int  LEN_W   = QPL_LEN_W,
    localparam int ADDR_W  = BLOCK_W + OFF_W
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_s_vld,
    output logic               o_s_rdy,
    input  logic [DATA_W-1:0]  i_s_data,
    input  logic [USER_W-1:0]  i_s_user,
    input  logic               i_s_last,
    input  logic               i_blk_full,
    input  logic [BLOCK_W:0]   i_blk_avail,
    output logic               o_alloc_req,
    input  logic               i_alloc_gnt,
    input  logic [BLOCK_W-1:0] i_alloc_idx,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    output logic               o_aux_we,
    output logic [BLOCK_W-1:0] o_aux_addr,
    output logic [BLOCK_W-1:0] o_aux_data,
    output logic               o_desc_vld,
    input  logic               i_desc_rdy,
    output logic [BLOCK_W-1:0] o_desc_head,
    output logic [LEN_W-1:0]   o_desc_len,
    output logic [USER_W-1:0]  o_desc_user,
    output logic               o_desc_ovf
);

    localparam logic [OFF_W-1:0] OFF_ONE = OFF_W'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [OFF_W-1:0]   off_reg;
    logic [BLOCK_W-1:0] cur_reg;
    desc_t              desc_reg;

    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic               aux_we_reg;
    logic [BLOCK_W-1:0] aux_addr_reg;
    logic [BLOCK_W-1:0] aux_data_reg;

    logic               nxt_vld;
    logic [BLOCK_W-1:0] nxt_idx;
    logic               s_rdy;
    logic               desc_vld;
    logic               accept;
    logic               at_boundary;
    logic               consume;
    logic [BLOCK_W-1:0] wr_blk;
    logic [OFF_W-1:0]   wr_off;
    logic               unused_blk_avail;

    // Free-block count is informational; control relies on i_blk_full alone.
    assign unused_blk_avail = ^i_blk_avail;

    qpl_blk_prefetch #(
        .BLOCK_W (BLOCK_W)
    ) u_prefetch (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_blk_full  (i_blk_full),
        .i_alloc_gnt (i_alloc_gnt),
        .i_alloc_idx (i_alloc_idx),
        .i_consume   (consume),
        .o_alloc_req (o_alloc_req),
        .o_nxt_vld   (nxt_vld),
        .o_nxt_idx   (nxt_idx)
    );

    // off_reg wraps to zero once a block is full, so zero inside a packet means
    // the next beat must open a fresh block.
    assign accept      = i_s_vld && s_rdy;
    assign at_boundary = (state_reg == ST_PKT) && (off_reg == '0);
    assign consume     = accept && ((state_reg == ST_IDLE) || at_boundary);
    assign wr_blk      = consume ? nxt_idx : cur_reg;
    assign wr_off      = consume ? '0 : off_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_PKT: begin
                if (accept) begin
                    state_next = i_s_last ? ST_DESC : ST_PKT;
                end
            end
            ST_DESC: begin
                if (i_desc_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_rdy    = 1'b0;
        desc_vld = 1'b0;
        case (state_reg)
            ST_IDLE: s_rdy    = nxt_vld;
            ST_PKT:  s_rdy    = (off_reg != '0) ? 1'b1 : nxt_vld;
            ST_DESC: desc_vld = 1'b1;
            default: begin
                s_rdy    = 1'b0;
                desc_vld = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            off_reg       <= '0;
            cur_reg       <= '0;
            desc_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            aux_we_reg    <= 1'b0;
            aux_addr_reg  <= '0;
            aux_data_reg  <= '0;
        end else begin
            mem_we_reg <= accept;
            aux_we_reg <= accept && at_boundary;

            if (accept) begin
                mem_addr_reg  <= {wr_blk, wr_off};
                mem_wdata_reg <= i_s_data;
                off_reg       <= consume ? OFF_ONE : off_reg + 1'b1;
                if (consume) begin
                    cur_reg <= nxt_idx;
                end
            end

            // The link is written only when the next block is really needed,
            // landing in the same cycle as that block's first data word.
            if (accept && at_boundary) begin
                aux_addr_reg <= cur_reg;
                aux_data_reg <= nxt_idx;
            end

            if (accept && (state_reg == ST_IDLE)) begin
                desc_reg.head <= nxt_idx;
                desc_reg.len  <= QPL_LEN_W'(1);
                desc_reg.user <= i_s_user;
                desc_reg.ovf  <= 1'b0;
            end else if (accept) begin
                if (&desc_reg.len) begin
                    desc_reg.ovf <= 1'b1;
                end else begin
                    desc_reg.len <= desc_reg.len + 1'b1;
                end
            end
        end
    end

    assign o_s_rdy     = s_rdy;
    assign o_mem_we    = mem_we_reg;
    assign o_mem_addr  = mem_addr_reg;
    assign o_mem_wdata = mem_wdata_reg;
    assign o_aux_we    = aux_we_reg;
    assign o_aux_addr  = aux_addr_reg;
    assign o_aux_data  = aux_data_reg;
    assign o_desc_vld  = desc_vld;
    assign o_desc_head = desc_reg.head;
    assign o_desc_len  = desc_reg.len;
    assign o_desc_user = desc_reg.user;
    assign o_desc_ovf  = desc_reg.ovf;

endmodule
